// File: rtl/key_track_encoder_pkg.sv
// key_track_encoder_pkg: shared sizes, FSM encoding and slot helper for the key/track encoder
package key_track_encoder_pkg;
  localparam int NUM_TRACKS = 4;
  localparam int NUM_KEYS = 16;
  localparam int CODE_W = 6;
  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam logic [CODE_W-1:0] CODE_REST = '0;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  typedef logic [NUM_TRACKS-1:0][CODE_W-1:0] slots_t;
  function automatic logic [NUM_TRACKS-1:0] lowest_free(input slots_t s);
    logic [NUM_TRACKS-1:0] f;
    for (int i = 0; i < NUM_TRACKS; i++) f[i] = s[i] == CODE_REST;
    return f & (~f + NUM_TRACKS'(1));
  endfunction
endpackage

// File: rtl/key_track_encoder_if.sv
// key_track_encoder_if: key inputs and per-track note outputs of the encoder
interface key_track_encoder_if;
  import key_track_encoder_pkg::*;
  logic [NUM_KEYS-1:0] keys;
  logic en;
  logic [CODE_W-1:0] track0, track1, track2, track3;
  logic changed;
  logic overflow;
  modport master(output keys, en, input track0, track1, track2, track3, changed, overflow);
  modport slave(input keys, en, output track0, track1, track2, track3, changed, overflow);
endinterface

// File: rtl/key_track_encoder_debouncer.sv
// key_debouncer: synchronizes keys, samples them on a periodic tick and reports debounced edges
module key_debouncer
  import key_track_encoder_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic edge_valid,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] rel
);
  localparam int CW = $clog2(TICK_CYCLES);
  logic [CW-1:0] cnt;
  logic [NUM_KEYS-1:0] s1, s2, samp, db, agree, db_nxt;
  logic tick;
  assign tick = cnt == CW'(TICK_CYCLES - 1);
  assign agree = ~(s2 ^ samp);
  assign db_nxt = (agree & s2) | (~agree & db);
  // edges stay stable between ticks; edge_valid marks the cycle they become fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      samp <= '0;
      db <= '0;
      press <= '0;
      rel <= '0;
      cnt <= '0;
      edge_valid <= 1'b0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      cnt <= tick ? '0 : cnt + CW'(1);
      edge_valid <= tick;
      if (tick) begin
        samp <= s2;
        db <= db_nxt;
        press <= db_nxt & ~db;
        rel <= db & ~db_nxt;
      end
    end
  end
endmodule

// File: rtl/key_track_encoder.sv
// key_track_encoder: allocates debounced key presses to four note tracks via a 16-step scan
module key_track_encoder
  import key_track_encoder_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000
) (
  input logic clk,
  input logic rst_n,
  key_track_encoder_if.slave bus
);
  logic edge_valid;
  logic [NUM_KEYS-1:0] press, rel;
  state_t st;
  logic [KEY_W-1:0] idx;
  slots_t trk, work, cleared, nxt;
  logic [NUM_TRACKS-1:0] hot;
  logic [CODE_W-1:0] code;
  logic alloc, ovf_pend, chg, ovf;
  key_debouncer #(.TICK_CYCLES(TICK_CYCLES)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .keys(bus.keys),
    .edge_valid(edge_valid),
    .press(press),
    .rel(rel)
  );
  assign code = CODE_W'(idx) + CODE_W'(1);
  assign alloc = press[idx] && bus.en;
  // release clears first so a slot freed this step is already free for the press logic
  always_comb begin
    cleared = work;
    for (int s = 0; s < NUM_TRACKS; s++) cleared[s] = (rel[idx] && work[s] == code) ? CODE_REST : work[s];
    hot = lowest_free(cleared);
    nxt = cleared;
    for (int s = 0; s < NUM_TRACKS; s++) nxt[s] = (alloc && hot[s]) ? code : cleared[s];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      idx <= '0;
      work <= '0;
      trk <= '0;
      ovf_pend <= 1'b0;
      chg <= 1'b0;
      ovf <= 1'b0;
    end else begin
      chg <= 1'b0;
      ovf <= 1'b0;
      case (st)
        IDLE: if (edge_valid && |(press | rel)) begin
          st <= SCAN;
          idx <= '0;
          work <= trk;
        end
        SCAN: begin
          work <= nxt;
          if (alloc && hot == '0) ovf_pend <= 1'b1;
          idx <= idx + KEY_W'(1);
          if (idx == KEY_W'(NUM_KEYS - 1)) st <= COMMIT;
        end
        COMMIT: begin
          trk <= work;
          chg <= work != trk;
          ovf <= ovf_pend;
          ovf_pend <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign bus.track0 = trk[0];
  assign bus.track1 = trk[1];
  assign bus.track2 = trk[2];
  assign bus.track3 = trk[3];
  assign bus.changed = chg;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_key_track_encoder.sv
// tb_key_track_encoder: directed checks of allocation, overflow, debounce, enable and reset
module tb_key_track_encoder;
  import key_track_encoder_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  int chg_tot = 0;
  int ovf_tot = 0;
  key_track_encoder_if bus();
  key_track_encoder #(.TICK_CYCLES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.changed === 1'b1) chg_tot++;
    if (bus.overflow === 1'b1) ovf_tot++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_tracks(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_t0"}, int'(bus.track0), a);
    chk({tag, "_t1"}, int'(bus.track1), b);
    chk({tag, "_t2"}, int'(bus.track2), c);
    chk({tag, "_t3"}, int'(bus.track3), d);
  endtask
  task automatic settle();
    repeat (136) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic step(input string tag, input logic [15:0] k, input int a, input int b, input int c,
                      input int d, input int ch, input int ov);
    int c0, o0;
    c0 = chg_tot;
    o0 = ovf_tot;
    bus.keys = k;
    settle();
    chk_tracks(tag, a, b, c, d);
    chk({tag, "_chg"}, chg_tot - c0, ch);
    chk({tag, "_ovf"}, ovf_tot - o0, ov);
  endtask
  initial begin
    int c0;
    int found;
    rst_n = 1'b0;
    bus.keys = '0;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    chk_tracks("rst", 0, 0, 0, 0);
    chk("rst_chg", int'(bus.changed), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    rst_n = 1'b1;
    step("p3", 16'h0008, 4, 0, 0, 0, 1, 0);
    step("r3", 16'h0000, 0, 0, 0, 0, 1, 0);
    step("p52", 16'h0024, 3, 6, 0, 0, 1, 0);
    step("r2p9", 16'h0220, 10, 6, 0, 0, 1, 0);
    step("rall", 16'h0000, 0, 0, 0, 0, 1, 0);
    step("h0_3", 16'h000F, 1, 2, 3, 4, 1, 0);
    step("p7", 16'h008F, 1, 2, 3, 4, 0, 1);
    step("rall2", 16'h0000, 0, 0, 0, 0, 1, 0);
    c0 = chg_tot;
    bus.keys = 16'h0002;
    repeat (32) @(negedge clk);
    bus.keys = 16'h0000;
    settle();
    chk_tracks("glitch", 0, 0, 0, 0);
    chk("glitch_chg", chg_tot - c0, 0);
    bus.en = 1'b0;
    step("en0", 16'h0002, 0, 0, 0, 0, 0, 0);
    bus.en = 1'b1;
    step("en1", 16'h0002, 0, 0, 0, 0, 0, 0);
    step("en_rel", 16'h0000, 0, 0, 0, 0, 0, 0);
    step("h0", 16'h0001, 1, 0, 0, 0, 1, 0);
    c0 = chg_tot;
    bus.keys = 16'h0011;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (dut.st == SCAN) found = 1;
    end
    chk("scan_seen", found, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_tracks("midrst", 0, 0, 0, 0);
    chk("midrst_chg", int'(bus.changed), 0);
    chk("midrst_ovf", int'(bus.overflow), 0);
    repeat (3) @(negedge clk);
    chk("midrst_nopulse", chg_tot - c0, 0);
    rst_n = 1'b1;
    settle();
    chk_tracks("after_rst", 1, 5, 0, 0);
    chk("after_rst_chg", chg_tot - c0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_track_encoder.md
KEY_TRACK_ENCODER -- requirements
Module: key_track_encoder

Interface
REQ-001 Parameter TICK_CYCLES, default 1_000_000, sets the debounce sample period in clk cycles; legal values are >= 32.
REQ-002 clk  input  1  System clock; all state is rising-edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 keys  input  16  Raw, asynchronous key/switch levels; 1 = pressed; keys[i] is key i.
REQ-005 en  input  1  Encoding enable; when 0, new presses are not allocated.
REQ-006 track0, track1, track2, track3  output  6 each  Per-track note code; 0 = rest; k in 1..16 = key k-1.
REQ-007 changed  output  1  One-cycle pulse when any trackN value changes.
REQ-008 overflow  output  1  One-cycle pulse when a new press found no free track.

Function
REQ-009 Each keys bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 A free-running tick counter SHALL count from 0 to TICK_CYCLES-1 and wrap to 0; the tick SHALL assert for one cycle at count TICK_CYCLES-1.
REQ-011 On each tick, the synchronized keys SHALL be sampled; the debounced state of key i SHALL update only when two consecutive samples agree.
REQ-012 The press edge of key i SHALL be the debounced state going 0->1; the release edge SHALL be 1->0; both SHALL be computed on the tick.
REQ-013 The FSM SHALL have states IDLE, SCAN and COMMIT; reset state is IDLE.
REQ-014 IDLE->SCAN on a tick where any press or release edge exists; otherwise the FSM SHALL remain in IDLE.
REQ-015 SCAN SHALL process one key per cycle, index 0 to 15 ascending, for exactly 16 cycles, then go to COMMIT; COMMIT lasts 1 cycle, then IDLE.
REQ-016 Release of key i during SCAN SHALL clear, in working copies, any slot holding code i+1.
REQ-017 Press of key i with en=1 during SCAN SHALL write code i+1 into the lowest-numbered free working slot.
REQ-018 A slot freed by a lower-index key in the same scan SHALL count as free for later keys.
REQ-019 Press of key i when no slot is free SHALL leave all slots unchanged and set a sticky overflow_pending bit.
REQ-020 A press with en=0 SHALL be ignored; that key is not allocated later while it stays held.
REQ-021 In COMMIT, track0..3 SHALL load the working slots.
REQ-022 changed SHALL pulse in the COMMIT cycle iff any track value differs from its previous value.
REQ-023 overflow SHALL pulse in the COMMIT cycle iff overflow_pending is set; overflow_pending then clears.
REQ-024 A held key SHALL keep its slot unchanged until its release, regardless of other keys.
REQ-025 Outputs SHALL change only in COMMIT, so latency from the tick is 17 clk cycles.
REQ-026 A slot SHALL never hold a code equal to another slot's nonzero code.
REQ-027 Ticks arriving outside IDLE cannot occur, since TICK_CYCLES >= 32; edges are latched at the tick and consumed by the scan.

Reset
REQ-028 While rst_n=0, track0..3 SHALL be 0, changed=0 and overflow=0.
REQ-029 While rst_n=0, the debounced state, samples and synchronizers SHALL be 0, the tick counter 0, the FSM IDLE and overflow_pending 0.
REQ-030 Reset asserted mid-SCAN SHALL abort the scan with no partial commit.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, NUM_TRACKS=4, NUM_KEYS=16, CODE_W=6 and CODE_REST=0.
REQ-032 Debounce (synchronizer, tick counter, sampling, edge detect) SHALL be sub-module key_debouncer; the allocator FSM stays in key_track_encoder.

Verification (TICK_CYCLES=32)
REQ-033 Press key 3, held 3 ticks -> 17 cycles after the confirming tick, track0=4 and changed pulses once; track1..3=0.
REQ-034 Press keys 5 and 2 together -> track0=3, track1=6.
REQ-035 Then release key 2 and press key 9 on the same tick -> track0=10, track1=6.
REQ-036 Hold keys 0..3, then press key 7 -> tracks unchanged (1,2,3,4), changed=0, overflow pulses once.
REQ-037 Glitch key 1 high for 1 tick only -> no output change.
REQ-038 Press key 1 with en=0 -> no allocation.
REQ-039 After the key 1 press with en=0, set en=1 while key 1 stays held -> still no allocation for key 1.
REQ-040 Assert rst_n=0 during SCAN -> all outputs 0 immediately, no changed pulse.
